// File: rtl/irq_controller_multi.sv
// Multi-channel interrupt controller.
// Latches N_IRQ request lines (per-channel level or edge mode) and masks them with mie.
// Picks one request by fixed priority, where index 0 is the highest.
// Raises a trap to the core and tracks the exception/ISR context until mret.
module irq_controller_multi #(
   parameter int unsigned      N_IRQ      = 16,
   parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
   parameter logic [31:0]      CAUSE_BASE = 32'h8000_0010
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             exception_i,
   input  logic [N_IRQ-1:0] irq_req_i,
   input  logic [N_IRQ-1:0] mie_i,
   input  logic             mret_i,
   output logic             irq_o,
   output logic [31:0]      irq_cause_o,
   output logic [N_IRQ-1:0] irq_ret_o,
   output logic [N_IRQ-1:0] irq_pending_o,
   output logic             in_isr_o
);

   localparam int unsigned IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXC     = 2'd1,
      S_IRQ     = 2'd2,
      S_IRQ_EXC = 2'd3
   } state_e;

   state_e           state_q;
   logic             in_isr_q;
   logic [IDW-1:0]   active_q;
   logic [N_IRQ-1:0] edge_pend_q;
   logic [N_IRQ-1:0] edge_pend_d;
   logic [N_IRQ-1:0] prev_q;

   logic [N_IRQ-1:0] pend;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] edge_set;
   logic [N_IRQ-1:0] edge_clr;
   logic [N_IRQ-1:0] ret_vec;
   logic [IDW-1:0]   sel_id;
   logic             any_elig;
   logic             take_irq;
   logic             ret_fire;

   // Pending view: edge channels come from storage, level channels pass straight through
   always_comb begin
      pend     = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & irq_req_i);
      eligible = pend & mie_i;
      any_elig = |eligible;
   end

   // Fixed-priority pick: the lowest set index of eligible wins
   always_comb begin
      logic found;
      found  = 1'b0;
      sel_id = '0;
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         if (eligible[k] && !found) begin
            sel_id = IDW'(k);
            found  = 1'b1;
         end
      end
   end

   // Trap and return qualifiers; a stalled core neither takes a trap nor retires an mret
   always_comb begin
      take_irq = (state_q == S_IDLE) & any_elig & ~exception_i & ~stall_i & ~mret_i;
      ret_fire = (state_q == S_IRQ) & mret_i & ~exception_i & ~stall_i;
   end

   // Edge pending update: a new rising edge overrides a clear from being taken in the same cycle
   always_comb begin
      edge_set = EDGE_MASK & irq_req_i & ~prev_q;
      edge_clr = '0;
      ret_vec  = '0;
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         edge_clr[k] = take_irq & (sel_id == IDW'(k));
         ret_vec[k]  = ret_fire & (active_q == IDW'(k));
      end
      edge_pend_d = ((edge_pend_q & ~edge_clr) | edge_set) & EDGE_MASK;
   end

   // Edge history and edge-pending storage; rising edges are still seen while stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         edge_pend_q <= '0;
         prev_q      <= '0;
      end else begin
         edge_pend_q <= edge_pend_d;
         prev_q      <= irq_req_i;
      end
   end

   // Trap/ISR context FSM; it holds while the core is stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         in_isr_q <= 1'b0;
         active_q <= '0;
      end else if (!stall_i) begin
         case (state_q)
            S_IDLE: begin
               if (exception_i) begin
                  state_q <= S_EXC;
               end else if (take_irq) begin
                  state_q  <= S_IRQ;
                  in_isr_q <= 1'b1;
                  active_q <= sel_id;
               end
            end
            S_EXC: begin
               if (mret_i) begin
                  state_q <= S_IDLE;
               end
            end
            S_IRQ: begin
               if (exception_i) begin
                  state_q <= S_IRQ_EXC;
               end else if (mret_i) begin
                  state_q  <= S_IDLE;
                  in_isr_q <= 1'b0;
               end
            end
            S_IRQ_EXC: begin
               if (mret_i) begin
                  state_q <= S_IRQ;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               in_isr_q <= 1'b0;
            end
         endcase
      end
   end

   // Output drive; every output is forced to zero while reset is asserted
   always_comb begin
      irq_o         = take_irq & ~rst_i;
      irq_cause_o   = irq_o ? (CAUSE_BASE + {{(32-IDW){1'b0}}, sel_id}) : '0;
      irq_ret_o     = rst_i ? '0 : ret_vec;
      irq_pending_o = rst_i ? '0 : pend;
      in_isr_o      = in_isr_q;
   end

endmodule

// File: tb/tb_irq_controller_multi.sv
// Self-checking bench for irq_controller_multi.
// Directed scenarios plus randomized traffic are compared against a flag-based reference model.
module tb_irq_controller_multi;

   localparam int unsigned N    = 16;
   localparam logic [15:0] EDGE = 16'h00FF;
   localparam logic [31:0] BASE = 32'h8000_0010;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        exception_i;
   logic [15:0] irq_req_i;
   logic [15:0] mie_i;
   logic        mret_i;
   logic        irq_o;
   logic [31:0] irq_cause_o;
   logic [15:0] irq_ret_o;
   logic [15:0] irq_pending_o;
   logic        in_isr_o;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Reference model state
   logic [15:0] m_epend, m_prev;
   bit          m_isr, m_exc;
   int          m_active;
   // Expected values for the cycle currently being driven
   logic [15:0] e_pend, e_elig, e_ret;
   logic [31:0] e_cause;
   bit          e_irq, e_isr;
   int          e_sel;

   always #5 clk_i = ~clk_i;

   irq_controller_multi #(
      .N_IRQ     (N),
      .EDGE_MASK (EDGE),
      .CAUSE_BASE(BASE)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .exception_i  (exception_i),
      .irq_req_i    (irq_req_i),
      .mie_i        (mie_i),
      .mret_i       (mret_i),
      .irq_o        (irq_o),
      .irq_cause_o  (irq_cause_o),
      .irq_ret_o    (irq_ret_o),
      .irq_pending_o(irq_pending_o),
      .in_isr_o     (in_isr_o)
   );

   function automatic int lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_epend = '0; m_prev = '0; m_isr = 0; m_exc = 0; m_active = 0;
   endtask

   // Drive one cycle's inputs at the falling edge and compute what the DUT should show
   task automatic drive(input bit st, input bit ex, input logic [15:0] rq, input logic [15:0] mk, input bit mr);
      @(negedge clk_i);
      stall_i = st; exception_i = ex; irq_req_i = rq; mie_i = mk; mret_i = mr;
      #1;
      e_pend  = (EDGE & m_epend) | (~EDGE & rq);
      e_elig  = e_pend & mk;
      e_sel   = lowest(e_elig);
      e_irq   = !m_isr && !m_exc && (e_elig != 0) && !ex && !st && !mr;
      e_cause = e_irq ? BASE + 32'(e_sel) : 32'h0;
      e_ret   = (m_isr && !m_exc && mr && !ex && !st) ? (16'h0001 << m_active) : 16'h0000;
      e_isr   = m_isr;
   endtask

   // Advance the model across the rising edge
   task automatic tick();
      logic [15:0] nxt;
      @(posedge clk_i);
      nxt = m_epend;
      if (e_irq) nxt[e_sel] = 1'b0;
      nxt     = nxt | (EDGE & irq_req_i & ~m_prev);
      m_epend = nxt;
      m_prev  = irq_req_i;
      if (!stall_i) begin
         if (!m_isr && !m_exc) begin
            if (exception_i) m_exc = 1;
            else if (e_irq) begin m_isr = 1; m_active = e_sel; end
         end else if (m_exc) begin
            if (mret_i) m_exc = 0;
         end else begin
            if (exception_i) m_exc = 1;
            else if (mret_i) m_isr = 0;
         end
      end
   endtask

   task automatic apply_reset(input bit mr);
      @(negedge clk_i);
      rst_i = 1'b1; stall_i = 0; exception_i = 0; irq_req_i = 16'hFFFF; mie_i = 16'hFFFF; mret_i = mr;
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      irq_req_i = '0; mie_i = '0; mret_i = 0; rst_i = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset(1'b0);
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq_o); else pass_cnt++;
      chk_cnt++; if (irq_cause_o !== 32'h0) $display("FAIL rst_cause got %h exp 0", irq_cause_o); else pass_cnt++;
      chk_cnt++; if (irq_pending_o !== 16'h0) $display("FAIL rst_pend got %h exp 0", irq_pending_o); else pass_cnt++;
      chk_cnt++; if (irq_ret_o !== 16'h0) $display("FAIL rst_ret got %h exp 0", irq_ret_o); else pass_cnt++;
      chk_cnt++; if (in_isr_o !== 1'b0) $display("FAIL rst_isr got %b exp 0", in_isr_o); else pass_cnt++;
      release_reset();
   endtask

   task automatic test_edge_single();
      drive(0, 0, 16'h0001, 16'h0001, 0);
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL t1_nolat got %b exp 0", irq_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'h0001, 0);
      chk_cnt++; if (irq_o !== 1'b1) $display("FAIL t1_irq got %b exp 1", irq_o); else pass_cnt++;
      chk_cnt++; if (irq_cause_o !== 32'h8000_0010) $display("FAIL t1_cause got %h exp 80000010", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'h0001, 0);
      chk_cnt++; if (in_isr_o !== 1'b1) $display("FAIL t1_isr got %b exp 1", in_isr_o); else pass_cnt++;
      chk_cnt++; if (irq_pending_o !== 16'h0) $display("FAIL t1_pclr got %h exp 0", irq_pending_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'h0001, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0001) $display("FAIL t1_ret got %h exp 0001", irq_ret_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_priority();
      drive(0, 0, 16'h0024, 16'hFFFF, 0);
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0012) $display("FAIL t2_cause2 got %h exp 80000012", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_pending_o !== 16'h0020) $display("FAIL t2_pend got %h exp 0020", irq_pending_o); else pass_cnt++;
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL t2_nonest got %b exp 0", irq_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0004) $display("FAIL t2_ret2 got %h exp 0004", irq_ret_o); else pass_cnt++;
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL t2_mretblk got %b exp 0", irq_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0015) $display("FAIL t2_cause5 got %h exp 80000015", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0020) $display("FAIL t2_ret5 got %h exp 0020", irq_ret_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_ret_pulse();
      drive(0, 0, 16'h0008, 16'hFFFF, 0);
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0013) $display("FAIL t3_cause got %h exp 80000013", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0008) $display("FAIL t3_ret got %h exp 0008", irq_ret_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0000) $display("FAIL t3_once got %h exp 0000", irq_ret_o); else pass_cnt++;
      chk_cnt++; if (in_isr_o !== 1'b0) $display("FAIL t3_idle got %b exp 0", in_isr_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_exc_priority();
      drive(0, 0, 16'h0002, 16'hFFFF, 0);
      tick();
      drive(0, 1, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL t4_excwin got %b exp 0", irq_o); else pass_cnt++;
      chk_cnt++; if (irq_cause_o !== 32'h0) $display("FAIL t4_cause0 got %h exp 0", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL t4_inexc got %b exp 0", irq_o); else pass_cnt++;
      chk_cnt++; if (irq_pending_o !== 16'h0002) $display("FAIL t4_kept got %h exp 0002", irq_pending_o); else pass_cnt++;
      chk_cnt++; if (in_isr_o !== 1'b0) $display("FAIL t4_isr got %b exp 0", in_isr_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0000) $display("FAIL t4_noret got %h exp 0000", irq_ret_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0011) $display("FAIL t4_after got %h exp 80000011", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0002) $display("FAIL t4_ret got %h exp 0002", irq_ret_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_stall();
      drive(0, 0, 16'h0010, 16'hFFFF, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 16'h0000, 16'hFFFF, 0);
         chk_cnt++; if (irq_o !== 1'b0) $display("FAIL t5_stall%0d got %b exp 0", i, irq_o); else pass_cnt++;
         tick();
      end
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_o !== 1'b1) $display("FAIL t5_go got %b exp 1", irq_o); else pass_cnt++;
      chk_cnt++; if (irq_cause_o !== 32'h8000_0014) $display("FAIL t5_cause got %h exp 80000014", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      tick();
   endtask

   task automatic test_isr_exc();
      drive(0, 0, 16'h0040, 16'hFFFF, 0);
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0016) $display("FAIL t6_cause got %h exp 80000016", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 1, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0000) $display("FAIL t6_excmret got %h exp 0000", irq_ret_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (in_isr_o !== 1'b1) $display("FAIL t6_isrexc got %b exp 1", in_isr_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0000) $display("FAIL t6_mret1 got %h exp 0000", irq_ret_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (in_isr_o !== 1'b1) $display("FAIL t6_back got %b exp 1", in_isr_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0040) $display("FAIL t6_mret2 got %h exp 0040", irq_ret_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (in_isr_o !== 1'b0) $display("FAIL t6_done got %b exp 0", in_isr_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_level_mask();
      drive(0, 0, 16'h0000, 16'hFFFF, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0000) $display("FAIL lm_idlemret got %h exp 0000", irq_ret_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0200, 16'h0000, 0);
      chk_cnt++; if (irq_pending_o !== 16'h0200) $display("FAIL lm_lvlpend got %h exp 0200", irq_pending_o); else pass_cnt++;
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL lm_masked got %b exp 0", irq_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0200, 16'h0200, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0019) $display("FAIL lm_lvl got %h exp 80000019", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0002, 16'h0000, 1);
      chk_cnt++; if (irq_ret_o !== 16'h0200) $display("FAIL lm_ret got %h exp 0200", irq_ret_o); else pass_cnt++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 16'h0000, 16'h0000, 0);
         chk_cnt++; if (irq_pending_o !== 16'h0002) $display("FAIL lm_edgekeep%0d got %h exp 0002", i, irq_pending_o); else pass_cnt++;
         tick();
      end
      drive(0, 0, 16'h0000, 16'h0002, 0);
      chk_cnt++; if (irq_cause_o !== 32'h8000_0011) $display("FAIL lm_unmask got %h exp 80000011", irq_cause_o); else pass_cnt++;
      tick();
      drive(0, 0, 16'h0400, 16'h0000, 1);
      tick();
      drive(0, 0, 16'h0000, 16'h0400, 0);
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL lm_lost got %b exp 0", irq_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_isr();
      drive(0, 0, 16'h0010, 16'hFFFF, 0);
      tick();
      drive(0, 0, 16'h0080, 16'hFFFF, 0);
      tick();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_pending_o !== 16'h0080) $display("FAIL rm_pend got %h exp 0080", irq_pending_o); else pass_cnt++;
      tick();
      apply_reset(1'b1);
      chk_cnt++; if (irq_ret_o !== 16'h0000) $display("FAIL rm_noret got %h exp 0000", irq_ret_o); else pass_cnt++;
      chk_cnt++; if (in_isr_o !== 1'b0) $display("FAIL rm_isr got %b exp 0", in_isr_o); else pass_cnt++;
      release_reset();
      drive(0, 0, 16'h0000, 16'hFFFF, 0);
      chk_cnt++; if (irq_pending_o !== 16'h0000) $display("FAIL rm_discard got %h exp 0000", irq_pending_o); else pass_cnt++;
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL rm_irq got %b exp 0", irq_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0));
         chk_cnt++; if (irq_o !== e_irq) $display("FAIL rnd_irq c%0d got %b exp %b", i, irq_o, e_irq); else pass_cnt++;
         chk_cnt++; if (irq_cause_o !== e_cause) $display("FAIL rnd_cause c%0d got %h exp %h", i, irq_cause_o, e_cause); else pass_cnt++;
         chk_cnt++; if (irq_ret_o !== e_ret) $display("FAIL rnd_ret c%0d got %h exp %h", i, irq_ret_o, e_ret); else pass_cnt++;
         chk_cnt++; if (irq_pending_o !== e_pend) $display("FAIL rnd_pend c%0d got %h exp %h", i, irq_pending_o, e_pend); else pass_cnt++;
         chk_cnt++; if (in_isr_o !== e_isr) $display("FAIL rnd_isr c%0d got %b exp %b", i, in_isr_o, e_isr); else pass_cnt++;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b0; stall_i = 0; exception_i = 0; irq_req_i = '0; mie_i = '0; mret_i = 0;
      model_reset();
      test_reset();
      test_edge_single();
      test_priority();
      test_ret_pulse();
      test_exc_priority();
      test_stall();
      test_isr_exc();
      test_level_mask();
      test_reset_mid_isr();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
